// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin sharing of one UART transmitter among NUM_REQ byte sources.
// Each grant captures one byte, raises tx_send until the transmitter reports busy,
// and then holds the grant until tx_busy falls again.
// Optional feature: define TX_ARB_TIMEOUT_EN to abandon a SEND that never sees
// tx_busy within TIMEOUT_CYCLES clocks; this pulses o_tx_error.
module tx_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic [NUM_REQ-1:0]         i_req_valid,
   input  logic [8*NUM_REQ-1:0]       i_req_data,
   output logic [NUM_REQ-1:0]         o_req_ack,
   output logic                       o_tx_send,
   output logic [7:0]                 o_tx_din,
   input  logic                       i_tx_busy,
   output logic [$clog2(NUM_REQ)-1:0] o_grant_id,
   output logic                       o_arb_busy,
   output logic                       o_tx_error
);

   localparam int GW = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   state_t              r_state, w_state;
   logic [GW-1:0]       r_last, w_last;
   logic [GW-1:0]       r_grant_id, w_grant_id;
   logic [NUM_REQ-1:0]  r_req_ack, w_req_ack;
   logic                r_tx_send, w_tx_send;
   logic [7:0]          r_tx_din, w_tx_din;
   logic                r_arb_busy, w_arb_busy;

   logic                w_found;
   logic [GW-1:0]       w_pick;
   logic [7:0]          w_pick_data;

`ifdef TX_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0]       r_cnt, w_cnt;
   logic                r_tx_error, w_tx_error;
`else
   logic                w_unused_timeout;
   assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

   // Round-robin search: first pending requester after the last served one.
   always_comb begin : rr_search
      logic [GW-1:0] v_idx;
      w_found     = 1'b0;
      w_pick      = '0;
      w_pick_data = 8'h00;
      v_idx       = '0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         v_idx = GW'((int'(r_last) + off) % NUM_REQ);
         if (!w_found && i_req_valid[v_idx]) begin
            w_found     = 1'b1;
            w_pick      = v_idx;
            w_pick_data = i_req_data[{v_idx, 3'b000} +: 8];
         end else begin
            w_found = w_found;
         end
      end
   end

   // Next-state and next-output logic; every output is registered from these.
   always_comb begin
      w_state    = r_state;
      w_last     = r_last;
      w_grant_id = r_grant_id;
      w_req_ack  = '0;
      w_tx_send  = r_tx_send;
      w_tx_din   = r_tx_din;
`ifdef TX_ARB_TIMEOUT_EN
      w_cnt      = r_cnt;
      w_tx_error = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
            if (!i_tx_busy && w_found) begin
               w_tx_din          = w_pick_data;
               w_tx_send         = 1'b1;
               w_req_ack[w_pick] = 1'b1;
               w_grant_id        = w_pick;
               w_state           = S_SEND;
`ifdef TX_ARB_TIMEOUT_EN
               w_cnt             = '0;
`endif
            end else begin
               w_state = S_IDLE;
            end
         end
         S_SEND: begin
            if (i_tx_busy) begin
               w_tx_send = 1'b0;
               w_state   = S_WAIT;
`ifdef TX_ARB_TIMEOUT_EN
            end else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
               // Transmitter never acknowledged: give up on this byte.
               w_tx_send  = 1'b0;
               w_tx_error = 1'b1;
               w_last     = r_grant_id;
               w_state    = S_IDLE;
            end else begin
               w_cnt = r_cnt + CW'(1);
`else
            end else begin
               w_state = S_SEND;
`endif
            end
         end
         S_WAIT: begin
            if (!i_tx_busy) begin
               w_last  = r_grant_id;
               w_state = S_IDLE;
            end else begin
               w_state = S_WAIT;
            end
         end
         default: begin
            w_state   = S_IDLE;
            w_tx_send = 1'b0;
         end
      endcase
      w_arb_busy = (w_state != S_IDLE);
   end

   // State and output registers; reset leaves requester 0 with top priority.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_last     <= GW'(NUM_REQ - 1);
         r_grant_id <= GW'(NUM_REQ - 1);
         r_req_ack  <= '0;
         r_tx_send  <= 1'b0;
         r_tx_din   <= 8'h00;
         r_arb_busy <= 1'b0;
`ifdef TX_ARB_TIMEOUT_EN
         r_cnt      <= '0;
         r_tx_error <= 1'b0;
`endif
      end else begin
         r_state    <= w_state;
         r_last     <= w_last;
         r_grant_id <= w_grant_id;
         r_req_ack  <= w_req_ack;
         r_tx_send  <= w_tx_send;
         r_tx_din   <= w_tx_din;
         r_arb_busy <= w_arb_busy;
`ifdef TX_ARB_TIMEOUT_EN
         r_cnt      <= w_cnt;
         r_tx_error <= w_tx_error;
`endif
      end
   end

   assign o_req_ack  = r_req_ack;
   assign o_tx_send  = r_tx_send;
   assign o_tx_din   = r_tx_din;
   assign o_grant_id = r_grant_id;
   assign o_arb_busy = r_arb_busy;
`ifdef TX_ARB_TIMEOUT_EN
   assign o_tx_error = r_tx_error;
`else
   assign o_tx_error = 1'b0;
`endif

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed testbench for tx_arbiter (NUM_REQ=4, TIMEOUT_CYCLES=100).
// The transmitter is modelled by driving i_tx_busy directly from the bench.
module tb_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ack;
   logic        tx_send;
   logic [7:0]  tx_din;
   logic        tx_busy;
   logic [1:0]  grant_id;
   logic        arb_busy;
   logic        tx_error;

   int n_total = 0;
   int n_bad   = 0;

   tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(100)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_req_valid(req_valid),
      .i_req_data (req_data),
      .o_req_ack  (req_ack),
      .o_tx_send  (tx_send),
      .o_tx_din   (tx_din),
      .i_tx_busy  (tx_busy),
      .o_grant_id (grant_id),
      .o_arb_busy (arb_busy),
      .o_tx_error (tx_error)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Hold reset for two cycles and check the reset values.
   task automatic do_reset();
      rst       = 1'b1;
      req_valid = 4'b0000;
      tx_busy   = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("rst_ack",   32'(req_ack),  32'h0);
      check_eq("rst_send",  32'(tx_send),  32'h0);
      check_eq("rst_din",   32'(tx_din),   32'h0);
      check_eq("rst_gid",   32'(grant_id), 32'h3);
      check_eq("rst_busy",  32'(arb_busy), 32'h0);
      check_eq("rst_error", 32'(tx_error), 32'h0);
      rst = 1'b0;
   endtask

   // One full transfer: expect grant to 'id' with byte 'b' within max_wait cycles.
   task automatic xfer(input string t, input int id, input logic [7:0] b,
                       input bit drop, input int max_wait);
      int         n;
      logic [3:0] exp_ack;
      exp_ack = 4'b0001 << id;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (req_ack == 4'b0000 && n < max_wait);
      check_eq({t, "_ack"},   32'(req_ack),  32'(exp_ack));
      check_eq({t, "_gid"},   32'(grant_id), 32'(id));
      check_eq({t, "_din"},   32'(tx_din),   32'(b));
      check_eq({t, "_send"},  32'(tx_send),  32'h1);
      check_eq({t, "_abusy"}, 32'(arb_busy), 32'h1);
      if (drop) req_valid[id] = 1'b0;
      @(negedge clk);
      check_eq({t, "_ack1"},  32'(req_ack),  32'h0);
      check_eq({t, "_send1"}, 32'(tx_send),  32'h1);
      tx_busy = 1'b1;
      @(negedge clk);
      check_eq({t, "_sendoff"}, 32'(tx_send),  32'h0);
      check_eq({t, "_wait"},    32'(arb_busy), 32'h1);
      repeat (3) @(negedge clk);
      check_eq({t, "_dinhold"}, 32'(tx_din),   32'(b));
      tx_busy = 1'b0;
      @(negedge clk);
      check_eq({t, "_idle"},    32'(arb_busy), 32'h0);
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = 4'b0000;
      req_data  = 32'h0;
      tx_busy   = 1'b0;

      // 1: single byte from requester 0
      do_reset();
      req_data  = {8'h00, 8'h00, 8'h00, 8'h41};
      req_valid = 4'b0001;
      xfer("t1", 0, 8'h41, 1'b1, 1);

      // 2: all requesting, held throughout
      req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
      do_reset();
      req_valid = 4'b1111;
      xfer("t2a", 0, 8'h10, 1'b0, 1);
      xfer("t2b", 1, 8'h11, 1'b0, 1);
      xfer("t2c", 2, 8'h12, 1'b0, 1);
      xfer("t2d", 3, 8'h13, 1'b0, 1);
      xfer("t2e", 0, 8'h10, 1'b0, 1);
      req_valid = 4'b0000;

      // 3: priority rotation
      do_reset();
      req_data  = {8'h33, 8'h32, 8'h31, 8'h30};
      req_valid = 4'b0101;
      xfer("t3a", 0, 8'h30, 1'b1, 2);
      xfer("t3b", 2, 8'h32, 1'b1, 2);
      req_valid = 4'b1001;
      xfer("t3c", 3, 8'h33, 1'b1, 2);
      xfer("t3d", 0, 8'h30, 1'b1, 2);

      // 4: reset while waiting for the transmitter
      do_reset();
      req_data  = {8'h53, 8'h52, 8'h51, 8'h50};
      req_valid = 4'b0100;
      @(negedge clk);
      check_eq("t4_ack", 32'(req_ack), 32'h4);
      req_valid = 4'b0000;
      tx_busy   = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check_eq("t4_inwait", 32'(arb_busy), 32'h1);
      #2 rst = 1'b1;
      #1;
      check_eq("t4_send",  32'(tx_send),  32'h0);
      check_eq("t4_ack0",  32'(req_ack),  32'h0);
      check_eq("t4_abusy", 32'(arb_busy), 32'h0);
      check_eq("t4_gid",   32'(grant_id), 32'h3);
      @(negedge clk);
      rst       = 1'b0;
      tx_busy   = 1'b0;
      req_valid = 4'b0010;
      xfer("t4b", 1, 8'h51, 1'b1, 1);

      // 5: transmitter busy while idle
      tx_busy   = 1'b1;
      req_data  = {8'h00, 8'h00, 8'h77, 8'h00};
      req_valid = 4'b0010;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_eq("t5_noack", 32'(req_ack), 32'h0);
      end
      tx_busy = 1'b0;
      xfer("t5", 1, 8'h77, 1'b1, 1);

      // 6: transmitter never answers
      do_reset();
      req_data  = {8'h00, 8'h00, 8'h00, 8'h66};
      req_valid = 4'b0001;
      @(negedge clk);
      check_eq("t6_ack", 32'(req_ack), 32'h1);
      req_valid = 4'b0000;
`ifdef TX_ARB_TIMEOUT_EN
      begin
         int k;
         k = 0;
         while (tx_error !== 1'b1 && k < 300) begin
            @(negedge clk);
            k++;
         end
         check_eq("t6_tmo_cycles", 32'(k), 32'd100);
         check_eq("t6_tmo_send",   32'(tx_send),  32'h0);
         check_eq("t6_tmo_idle",   32'(arb_busy), 32'h0);
         @(negedge clk);
         check_eq("t6_tmo_pulse",  32'(tx_error), 32'h0);
      end
`else
      begin
         bit send_ok;
         bit err_ok;
         send_ok = 1'b1;
         err_ok  = 1'b1;
         for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (tx_send !== 1'b1) send_ok = 1'b0;
            if (tx_error !== 1'b0) err_ok = 1'b0;
         end
         check_eq("t6_send_held", 32'(send_ok), 32'h1);
         check_eq("t6_no_error",  32'(err_ok),  32'h1);
         check_eq("t6_busy",      32'(arb_busy), 32'h1);
      end
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
